// File: rtl/oscillator_bank_pkg.sv
// Shared constants and elaboration-time helpers for the multi-voice oscillator bank.
// The noise waveform is built only when OSC_BANK_NOISE_EN is defined.
package oscillator_bank_pkg;

    localparam logic [1:0] ADDR_INCREMENT  = 2'd0;
    localparam logic [1:0] ADDR_PULSEWIDTH = 2'd1;
    localparam logic [1:0] ADDR_CTRL       = 2'd2;
    localparam logic [1:0] ADDR_PHASE      = 2'd3;

    localparam logic [2:0] WAVE_SAW    = 3'd0;
    localparam logic [2:0] WAVE_TRI    = 3'd1;
    localparam logic [2:0] WAVE_SQUARE = 3'd2;
    localparam logic [2:0] WAVE_PULSE  = 3'd3;
    localparam logic [2:0] WAVE_NOISE  = 3'd4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int midpoint(input int bitdepth);
        return (1 << (bitdepth - 1)) - 1;
    endfunction

    function automatic int default_pulse_width(input int bitdepth);
        return 1 << (bitdepth - 4);
    endfunction

    // Smallest s with 2**s >= n; n never exceeds 16 voices.
    function automatic int shift_for_count(input int n);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < n) s = i + 1;
        end
        return s;
    endfunction

endpackage

// File: rtl/oscillator_bank_voice.sv
// One oscillator voice: config registers, phase accumulator, sub-octave toggle
// and the registered waveform sample (stage 1). Noise input exists only with OSC_BANK_NOISE_EN.
module osc_voice
    import oscillator_bank_pkg::*;
#(
    parameter  int BITDEPTH    = 12,
    parameter  int BITFRACTION = 8,
    localparam int ACCW        = BITDEPTH + BITFRACTION
) (
    input  logic                sample_clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [ACCW-1:0]     cfg_wdata,
`ifdef OSC_BANK_NOISE_EN
    input  logic [BITDEPTH-1:0] noise_sample,
`endif
    output logic [BITDEPTH-1:0] sample,
    output logic                sample_en
);

    localparam logic [BITDEPTH-1:0] PW_DEFAULT = BITDEPTH'(default_pulse_width(BITDEPTH));

    logic [ACCW-1:0]     inc;
    logic [ACCW-1:0]     acc;
    logic [BITDEPTH-1:0] pulse_width;
    logic [3:0]          ctrl;
    logic                sub_toggle;

    logic [ACCW:0]       acc_sum;
    logic                phase_we;
    logic [2:0]          wave;
    logic [BITDEPTH-1:0] saw;
    logic [BITDEPTH-1:0] tri_lo;
    logic [BITDEPTH-1:0] tri_wave;
    logic [BITDEPTH-1:0] wave_next;

    assign acc_sum  = {1'b0, acc} + {1'b0, inc};
    assign phase_we = cfg_we && (cfg_addr == ADDR_PHASE);
    assign wave     = ctrl[3:1];
    assign saw      = acc[ACCW-1 -: BITDEPTH];
    assign tri_lo   = acc[ACCW-2 -: BITDEPTH];
    assign tri_wave = acc[ACCW-1] ? ~tri_lo : tri_lo;

    always_comb begin
        wave_next = saw;
        case (wave)
            WAVE_TRI:    wave_next = tri_wave;
            WAVE_SQUARE: wave_next = {BITDEPTH{sub_toggle}};
            WAVE_PULSE:  wave_next = (saw < pulse_width) ? '1 : '0;
`ifdef OSC_BANK_NOISE_EN
            WAVE_NOISE:  wave_next = noise_sample;
`endif
            default:     wave_next = saw;
        endcase
    end

    always_ff @(posedge sample_clock) begin
        if (reset) begin
            inc         <= '0;
            acc         <= '0;
            pulse_width <= PW_DEFAULT;
            ctrl        <= '0;
            sub_toggle  <= 1'b0;
            sample      <= '0;
            sample_en   <= 1'b0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_INCREMENT:  inc         <= cfg_wdata;
                    ADDR_PULSEWIDTH: pulse_width <= cfg_wdata[BITDEPTH-1:0];
                    ADDR_CTRL:       ctrl        <= cfg_wdata[3:0];
                    default: ;
                endcase
            end
            // A phase write replaces this edge's advance and restarts the sub-octave.
            if (phase_we) begin
                acc        <= cfg_wdata;
                sub_toggle <= 1'b0;
            end else begin
                acc <= acc_sum[ACCW-1:0];
                if (acc_sum[ACCW]) sub_toggle <= ~sub_toggle;
            end
            sample    <= wave_next;
            sample_en <= ctrl[0];
        end
    end

endmodule

// File: rtl/oscillator_bank.sv
// Multi-voice oscillator bank: config decode, voices, shared noise LFSR, mix and attenuation.
// Define OSC_BANK_NOISE_EN to build the LFSR and enable the noise waveform (code 4).
module oscillator_bank
    import oscillator_bank_pkg::*;
#(
    parameter  int NUM_VOICES  = 4,
    parameter  int BITDEPTH    = 12,
    parameter  int BITFRACTION = 8,
    localparam int ACCW        = BITDEPTH + BITFRACTION,
    localparam int VW          = $clog2(NUM_VOICES) + 1
) (
    input  logic                sample_clock,
    input  logic                reset,
    // Config port has no handshake: every cycle with cfg_we=1 is a completed write.
    input  logic                cfg_we,
    input  logic [VW-1:0]       cfg_voice,
    input  logic [1:0]          cfg_addr,
    input  logic [ACCW-1:0]     cfg_wdata,
    output logic [BITDEPTH-1:0] out,
    output logic                out_valid
);

    localparam int CW = $clog2(NUM_VOICES + 1);
    localparam int SW = BITDEPTH + CW;
    localparam logic [BITDEPTH-1:0] MID = BITDEPTH'(midpoint(BITDEPTH));

    logic [BITDEPTH-1:0]   samples [NUM_VOICES];
    logic [NUM_VOICES-1:0] sample_en;
    logic [SW-1:0]         sum_next;
    logic [SW-1:0]         sum_reg;
    logic [CW-1:0]         n_next;
    logic [CW-1:0]         n_reg;
    logic [1:0]            valid_pipe;

`ifdef OSC_BANK_NOISE_EN
    logic [15:0]         lfsr;
    logic [BITDEPTH-1:0] noise_sample;

    assign noise_sample = lfsr[15 -: BITDEPTH];

    always_ff @(posedge sample_clock) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
`endif

    // Out-of-range cfg_voice matches no index, so such writes fall away here.
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        osc_voice #(
            .BITDEPTH    (BITDEPTH),
            .BITFRACTION (BITFRACTION)
        ) u_voice (
            .sample_clock (sample_clock),
            .reset        (reset),
            .cfg_we       (cfg_we && (cfg_voice == VW'(gi))),
            .cfg_addr     (cfg_addr),
            .cfg_wdata    (cfg_wdata),
`ifdef OSC_BANK_NOISE_EN
            .noise_sample (noise_sample),
`endif
            .sample       (samples[gi]),
            .sample_en    (sample_en[gi])
        );
    end

    always_comb begin
        sum_next = '0;
        n_next   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (sample_en[i]) begin
                sum_next = sum_next + SW'(samples[i]);
                n_next   = n_next + CW'(1);
            end
        end
    end

    always_ff @(posedge sample_clock) begin
        if (reset) begin
            sum_reg    <= '0;
            n_reg      <= '0;
            out        <= MID;
            valid_pipe <= '0;
            out_valid  <= 1'b0;
        end else begin
            sum_reg    <= sum_next;
            n_reg      <= n_next;
            // Shifting by ceil(log2 n) keeps n full-scale samples within BITDEPTH.
            out        <= (n_reg == '0) ? MID
                          : BITDEPTH'(sum_reg >> shift_for_count(int'(n_reg)));
            valid_pipe <= {valid_pipe[0], 1'b1};
            out_valid  <= valid_pipe[1];
        end
    end

endmodule

// File: tb/tb_oscillator_bank.sv
// Directed bench for oscillator_bank with an arithmetic reference model and per-cycle compare.
module tb_oscillator_bank;

    localparam int NV    = 4;
    localparam int BD    = 12;
    localparam int ACCW  = 20;
    localparam int ACCMOD = 1 << ACCW;
    localparam int MIDV  = 'h7FF;
    localparam int FULL  = 'hFFF;

    logic            clk;
    logic            reset;
    logic            cfg_we;
    logic [2:0]      cfg_voice;
    logic [1:0]      cfg_addr;
    logic [ACCW-1:0] cfg_wdata;
    logic [BD-1:0]   out;
    logic            out_valid;

    int n_compared;
    int n_mismatched;

    int m_inc  [NV];
    int m_acc  [NV];
    int m_pw   [NV];
    int m_ctrl [NV];
    int m_sub  [NV];
    int m_lfsr;
    int since_reset;
    bit model_ready;
    logic [BD-1:0] exp_q [$];
    logic [BD-1:0] exp_out;
    logic          exp_valid;

    oscillator_bank #(
        .NUM_VOICES  (NV),
        .BITDEPTH    (BD),
        .BITFRACTION (8)
    ) dut (
        .sample_clock (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_voice    (cfg_voice),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .out          (out),
        .out_valid    (out_valid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mixed sample the voices should produce from the current model state.
    function automatic logic [BD-1:0] model_mix();
        int sum, n, p, s, saw, t, wave;
        sum = 0;
        n = 0;
        for (int v = 0; v < NV; v++) begin
            saw = m_acc[v] / 256;
            wave = (m_ctrl[v] / 2) % 8;
            case (wave)
                1: begin
                    t = (m_acc[v] / 128) % 4096;
                    s = (m_acc[v] >= ACCMOD / 2) ? FULL - t : t;
                end
                2: s = m_sub[v] ? FULL : 0;
                3: s = (saw < m_pw[v]) ? FULL : 0;
`ifdef OSC_BANK_NOISE_EN
                4: s = (m_lfsr / 16) % 4096;
`endif
                default: s = saw;
            endcase
            if (m_ctrl[v] % 2 == 1) begin
                sum += s;
                n++;
            end
        end
        if (n == 0) return BD'(MIDV);
        p = 1;
        while (p < n) p *= 2;
        return BD'(sum / p);
    endfunction

    // reference model, advanced at every rising edge from the inputs the DUT samples
    initial begin
        model_ready = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int v = 0; v < NV; v++) begin
                    m_inc[v] = 0; m_acc[v] = 0; m_pw[v] = 'h100; m_ctrl[v] = 0; m_sub[v] = 0;
                end
                m_lfsr = 'hACE1;
                exp_q.delete();
                exp_q.push_back(BD'(MIDV));
                exp_q.push_back(BD'(MIDV));
                exp_out = BD'(MIDV);
                exp_valid = 1'b0;
                since_reset = 0;
                model_ready = 1'b1;
            end else begin
                exp_q.push_back(model_mix());
                exp_out = exp_q.pop_front();
                since_reset++;
                exp_valid = (since_reset >= 3);
                for (int v = 0; v < NV; v++) begin
                    if (cfg_we && int'(cfg_voice) == v && cfg_addr == 2'd3) begin
                        m_acc[v] = int'(cfg_wdata);
                        m_sub[v] = 0;
                    end else begin
                        m_acc[v] += m_inc[v];
                        if (m_acc[v] >= ACCMOD) begin
                            m_acc[v] -= ACCMOD;
                            m_sub[v] = 1 - m_sub[v];
                        end
                    end
                end
                if (cfg_we && int'(cfg_voice) < NV) begin
                    case (cfg_addr)
                        2'd0: m_inc[cfg_voice]  = int'(cfg_wdata);
                        2'd1: m_pw[cfg_voice]   = int'(cfg_wdata) % 4096;
                        2'd2: m_ctrl[cfg_voice] = int'(cfg_wdata) % 16;
                        default: ;
                    endcase
                end
                if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 'hB400;
                else                 m_lfsr = m_lfsr / 2;
            end
        end
    end

    // scoreboard compare, every cycle after the first reset edge
    initial begin
        forever begin
            @(negedge clk);
            if (model_ready) begin
                n_compared++;
                if (out !== exp_out) begin
                    n_mismatched++;
                    $display("FAIL out_model t=%0t: got %h expected %h", $time, out, exp_out);
                end
                n_compared++;
                if (out_valid !== exp_valid) begin
                    n_mismatched++;
                    $display("FAIL valid_model t=%0t: got %b expected %b", $time, out_valid, exp_valid);
                end
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input int voice, input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_voice = 3'(voice);
        cfg_addr  = 2'(addr);
        cfg_wdata = ACCW'(data);
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic check(input string name, input logic [BD-1:0] act, input logic [BD-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // directed stimulus
    initial begin
        n_compared = 0;
        n_mismatched = 0;
        reset = 1'b1;
        cfg_we = 1'b0;
        cfg_voice = '0;
        cfg_addr = '0;
        cfg_wdata = '0;
        tick(3);
        check("reset_out", out, 12'h7FF);
        check("reset_valid", {11'd0, out_valid}, 12'd0);
        reset = 1'b0;
        tick(2);
        check("valid_edge2", {11'd0, out_valid}, 12'd0);
        tick(1);
        check("valid_edge3", {11'd0, out_valid}, 12'd1);
        check("idle_mid", out, 12'h7FF);
        tick(5);

        // saw on voice 0
        cfg_write(0, 0, 'h100);
        cfg_write(0, 2, 'h1);
        tick(3);
        check("saw_first", out, 12'h001);
        tick(10);
        check("saw_step", out, 12'h00B);
        cfg_write(0, 3, 'hFFE00);
        tick(3);
        check("saw_ffe", out, 12'hFFE);
        tick(1);
        check("saw_fff", out, 12'hFFF);
        tick(1);
        check("saw_wrap", out, 12'h000);

        // triangle, frozen phase; then wave 6 behaves as saw
        cfg_write(0, 2, 'h3);
        cfg_write(0, 0, 'h1000);
        tick(300);
        cfg_write(0, 0, 0);
        cfg_write(0, 3, 'h40000);
        tick(3);
        check("tri_frozen", out, 12'h800);
        cfg_write(0, 2, 13);
        tick(3);
        check("wave6_saw", out, 12'h400);

        // sub-octave square
        cfg_write(0, 0, 'h100);
        cfg_write(0, 2, 5);
        cfg_write(0, 3, 'hFFF00);
        tick(3);
        check("sq_low", out, 12'h000);
        tick(1);
        check("sq_high", out, 12'hFFF);
        tick(100);
        cfg_write(0, 3, 0);
        tick(2);
        check("sq_before_clear", out, 12'hFFF);
        tick(1);
        check("sq_cleared", out, 12'h000);

        // pulse on voice 1, then mixed with voice 0 saw
        cfg_write(0, 2, 0);
        cfg_write(1, 1, 'h400);
        cfg_write(1, 0, 'h100);
        cfg_write(1, 2, 7);
        cfg_write(1, 3, 0);
        tick(3);
        check("pulse_high", out, 12'hFFF);
        tick(1023);
        check("pulse_last_high", out, 12'hFFF);
        tick(1);
        check("pulse_low", out, 12'h000);
        cfg_write(0, 2, 1);
        tick(300);

        // three frozen pulse voices at phase 0
        for (int v = 0; v < 3; v++) begin
            cfg_write(v, 0, 0);
            cfg_write(v, 2, 7);
            cfg_write(v, 3, 0);
        end
        tick(3);
        check("three_pulse", out, 12'hBFF);
        cfg_write(4, 2, 0);
        cfg_write(7, 2, 0);
        tick(5);
        check("bad_voice_ignored", out, 12'hBFF);

        // reset mid-stream with a simultaneous write
        reset = 1'b1;
        cfg_we = 1'b1;
        cfg_voice = 3'd3;
        cfg_addr = 2'd2;
        cfg_wdata = ACCW'(7);
        @(negedge clk);
        reset = 1'b0;
        cfg_we = 1'b0;
        check("rst_mid_out", out, 12'h7FF);
        check("rst_mid_valid", {11'd0, out_valid}, 12'd0);
        tick(2);
        check("rst_mid_valid2", {11'd0, out_valid}, 12'd0);
        tick(1);
        check("rst_mid_valid3", {11'd0, out_valid}, 12'd1);
        tick(10);
        check("rst_write_lost", out, 12'h7FF);

        // wave 4 (noise when built in, saw otherwise) alongside a triangle
        cfg_write(0, 0, 'h300);
        cfg_write(0, 2, 9);
        cfg_write(2, 0, 'h2345);
        cfg_write(2, 2, 3);
        tick(200);

        tick(2);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
